instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit.sv | 215 +++++++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: requests instruction blocks from DDR through the
// decoder load port, streams each resident block out of instruction memory
// through a small credit-controlled prefetch FIFO, and hands words to the
// decoder with a last-of-block marker.
//
// Handshakes: the decoder side is valid/ready. inst_valid stays high and
// inst_data/inst_last stay stable until the cycle inst_ready is sampled
// high; a word transfers on every rising edge where both are 1. The memory
// side is credit based: imem_rd_req is raised only while queued words plus
// reads in flight are below FIFO_DEPTH, so every returned imem_rd_valid
// always finds a free slot.
module instruction_fetch_unit #(
    parameter int INST_DATA_WIDTH = 32,
    parameter int INST_ADDR_WIDTH = 10,
    parameter int AXI_ADDR_WIDTH  = 42,
    parameter int MEM_REQ_W       = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [AXI_ADDR_WIDTH-1:0]  inst_base_addr,
    input  logic [INST_ADDR_WIDTH:0]   inst_block_size,
    input  logic [15:0]                num_blocks,
    output logic [AXI_ADDR_WIDTH-1:0]  decoder_ld_addr,
    output logic [MEM_REQ_W-1:0]       decoder_ld_req_size,
    output logic                       decoder_ld_req_in,
    input  logic                       imem_block_ready,
    output logic                       imem_rd_req,
    output logic [INST_ADDR_WIDTH-1:0] imem_rd_addr,
    input  logic [INST_DATA_WIDTH-1:0] imem_rd_data,
    input  logic                       imem_rd_valid,
    output logic                       imem_rd_block_done,
    output logic [INST_DATA_WIDTH-1:0] inst_data,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic                       inst_last,
    output logic                       busy,
    output logic                       done
);

    localparam int BYTES = INST_DATA_WIDTH / 8;
    localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int SW    = INST_ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_REQ   = 3'd1,
        WAIT_READY = 3'd2,
        FETCH      = 3'd3,
        BLOCK_DONE = 3'd4,
        DONE       = 3'd5
    } state_t;

    state_t                     state_q;
    logic [AXI_ADDR_WIDTH-1:0]  base_q;
    logic [AXI_ADDR_WIDTH-1:0]  offset_q;
    logic [SW-1:0]              size_q;
    logic [15:0]                nblk_q;
    logic [15:0]                idx_q;
    logic [AXI_ADDR_WIDTH-1:0]  ld_addr_q;
    logic [MEM_REQ_W-1:0]       ld_size_q;
    logic                       ld_toggle_q;
    logic [SW-1:0]              rd_ptr_q;
    logic [SW-1:0]              ret_cnt_q;
    logic                       block_done_q;
    logic                       done_q;
    logic                       busy_q;

    logic [INST_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]      last_q;
    logic [PW-1:0]              wr_idx_q;
    logic [PW-1:0]              rd_idx_q;
    logic [CW-1:0]              cnt_q;
    logic [CW-1:0]              outst_q;

    logic                       in_fetch;
    logic [CW:0]                in_flight;
    logic                       credit_ok;
    logic                       push;
    logic                       pop;
    logic                       push_last;
    logic [SW-1:0]              ret_next;
    logic [AXI_ADDR_WIDTH-1:0]  size_bytes;
    logic [16:0]                idx_next;

    assign in_fetch   = (state_q == FETCH);
    assign in_flight  = {1'b0, cnt_q} + {1'b0, outst_q};
    assign credit_ok  = in_flight < (CW + 1)'(FIFO_DEPTH);
    // Returns are only accepted against an outstanding read, so stray
    // valids (outside FETCH or unsolicited) can never corrupt the queue.
    assign push       = in_fetch && imem_rd_valid && (outst_q != '0);
    assign pop        = inst_valid && inst_ready;
    assign ret_next   = ret_cnt_q + 1'b1;
    assign push_last  = (ret_next == size_q);
    assign size_bytes = AXI_ADDR_WIDTH'(size_q) * AXI_ADDR_WIDTH'(BYTES);
    assign idx_next   = {1'b0, idx_q} + 17'd1;

    assign imem_rd_req        = in_fetch && (rd_ptr_q < size_q) && credit_ok;
    assign imem_rd_addr       = rd_ptr_q[INST_ADDR_WIDTH-1:0];
    assign inst_valid         = (cnt_q != '0);
    assign inst_data          = inst_valid ? mem_q[rd_idx_q] : '0;
    assign inst_last          = inst_valid && last_q[rd_idx_q];
    assign decoder_ld_addr    = ld_addr_q;
    assign decoder_ld_req_size = ld_size_q;
    assign decoder_ld_req_in  = ld_toggle_q;
    assign imem_rd_block_done = block_done_q;
    assign done               = done_q;
    assign busy               = busy_q;

    // Prefetch FIFO payload; storage needs no reset because inst_data is
    // gated by inst_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_idx_q]  <= imem_rd_data;
            last_q[wr_idx_q] <= push_last;
        end
    end

    // FIFO pointers, occupancy and reads-in-flight count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            cnt_q    <= '0;
            outst_q  <= '0;
        end else begin
            if (push) wr_idx_q <= wr_idx_q + 1'b1;
            if (pop)  rd_idx_q <= rd_idx_q + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (!push && pop) cnt_q <= cnt_q - 1'b1;
            if (imem_rd_req && !push)      outst_q <= outst_q + 1'b1;
            else if (!imem_rd_req && push) outst_q <= outst_q - 1'b1;
        end
    end

    // Program sequencing FSM with registered load port and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            base_q       <= '0;
            offset_q     <= '0;
            size_q       <= '0;
            nblk_q       <= '0;
            idx_q        <= '0;
            ld_addr_q    <= '0;
            ld_size_q    <= '0;
            ld_toggle_q  <= 1'b0;
            rd_ptr_q     <= '0;
            ret_cnt_q    <= '0;
            block_done_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            block_done_q <= 1'b0;
            done_q       <= 1'b0;
            if (imem_rd_req) rd_ptr_q  <= rd_ptr_q + 1'b1;
            if (push)        ret_cnt_q <= ret_next;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        base_q   <= inst_base_addr;
                        size_q   <= inst_block_size;
                        nblk_q   <= num_blocks;
                        idx_q    <= '0;
                        offset_q <= '0;
                        busy_q   <= 1'b1;
                        if (inst_block_size == '0 || num_blocks == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= LOAD_REQ;
                        end
                    end
                end
                LOAD_REQ: begin
                    ld_addr_q   <= base_q + offset_q;
                    ld_size_q   <= MEM_REQ_W'(size_bytes);
                    ld_toggle_q <= ~ld_toggle_q;
                    state_q     <= WAIT_READY;
                end
                WAIT_READY: begin
                    if (imem_block_ready) begin
                        rd_ptr_q  <= '0;
                        ret_cnt_q <= '0;
                        state_q   <= FETCH;
                    end
                end
                FETCH: begin
                    if (pop && inst_last) begin
                        block_done_q <= 1'b1;
                        state_q      <= BLOCK_DONE;
                    end
                end
                BLOCK_DONE: begin
                    if (idx_next < {1'b0, nblk_q}) begin
                        idx_q    <= idx_q + 1'b1;
                        offset_q <= offset_q + size_bytes;
                        state_q  <= LOAD_REQ;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a negedge memory/decoder model
// answers load toggles and reads, records what the decoder receives, and
// each test task compares against hand-derived expectations.
module tb_instruction_fetch_unit;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int XW    = 42;
    localparam int RW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [XW-1:0] inst_base_addr = '0;
    logic [AW:0]   inst_block_size = '0;
    logic [15:0]   num_blocks = '0;
    logic [XW-1:0] decoder_ld_addr;
    logic [RW-1:0] decoder_ld_req_size;
    logic          decoder_ld_req_in;
    logic          imem_block_ready = 1'b0;
    logic          imem_rd_req;
    logic [AW-1:0] imem_rd_addr;
    logic [DW-1:0] imem_rd_data = '0;
    logic          imem_rd_valid = 1'b0;
    logic          imem_rd_block_done;
    logic [DW-1:0] inst_data;
    logic          inst_valid;
    logic          inst_ready = 1'b0;
    logic          inst_last;
    logic          busy;
    logic          done;

    instruction_fetch_unit dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .inst_base_addr      (inst_base_addr),
        .inst_block_size     (inst_block_size),
        .num_blocks          (num_blocks),
        .decoder_ld_addr     (decoder_ld_addr),
        .decoder_ld_req_size (decoder_ld_req_size),
        .decoder_ld_req_in   (decoder_ld_req_in),
        .imem_block_ready    (imem_block_ready),
        .imem_rd_req         (imem_rd_req),
        .imem_rd_addr        (imem_rd_addr),
        .imem_rd_data        (imem_rd_data),
        .imem_rd_valid       (imem_rd_valid),
        .imem_rd_block_done  (imem_rd_block_done),
        .inst_data           (inst_data),
        .inst_valid          (inst_valid),
        .inst_ready          (inst_ready),
        .inst_last           (inst_last),
        .busy                (busy),
        .done                (done)
    );

    // Clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    int          cyc = 0;
    int          cur_block = -1;
    int          rdy_cnt = 0;
    int          ready_delay = 3;
    int          lat_min = 1;
    int          lat_max = 1;
    int          ready_mode = 0;
    int          req_cnt = 0;
    int          pop_cnt = 0;
    int          bd_cnt = 0;
    int          done_cnt = 0;
    int          ovf_err = 0;
    int          stab_err = 0;
    int          last_due = 0;
    logic        tog_last = 1'b0;
    logic [7:0]  salt = 8'h5A;
    logic        hold_prev = 1'b0;
    logic [32:0] held;
    int          pend_due[$];
    logic [DW-1:0] pend_data[$];
    logic [32:0] got_q[$];
    logic [32:0] exp_q[$];
    logic [XW-1:0] tog_addr_q[$];
    logic [RW-1:0] tog_size_q[$];

    function automatic logic [DW-1:0] mem_word(input logic [7:0] s, input int b, input int w);
        return {s, 8'(b), 16'(w)};
    endfunction

    // Memory, loader and decoder model, all acting on the falling edge.
    always @(negedge clk) begin
        int due;
        cyc++;
        if (done) done_cnt++;
        if (imem_rd_block_done) bd_cnt++;
        if (reset) begin
            pend_due.delete();
            pend_data.delete();
            imem_rd_valid    = 1'b0;
            imem_block_ready = 1'b0;
            rdy_cnt          = 0;
            tog_last         = 1'b0;
            hold_prev        = 1'b0;
            last_due         = 0;
        end else begin
            if (decoder_ld_req_in !== tog_last) begin
                tog_last = decoder_ld_req_in;
                tog_addr_q.push_back(decoder_ld_addr);
                tog_size_q.push_back(decoder_ld_req_size);
                cur_block++;
                imem_block_ready = 1'b0;
                rdy_cnt = ready_delay;
            end else if (rdy_cnt > 0) begin
                rdy_cnt--;
                if (rdy_cnt == 0) imem_block_ready = 1'b1;
            end
            if (imem_rd_block_done) imem_block_ready = 1'b0;

            imem_rd_valid = 1'b0;
            imem_rd_data  = '0;
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                void'(pend_due.pop_front());
                imem_rd_data  = pend_data.pop_front();
                imem_rd_valid = 1'b1;
            end
            if (imem_rd_req) begin
                req_cnt++;
                due = cyc + int'($urandom_range(lat_max, lat_min));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend_due.push_back(due);
                pend_data.push_back(mem_word(salt, cur_block, int'(imem_rd_addr)));
            end

            if (hold_prev && (!inst_valid || {inst_last, inst_data} !== held)) stab_err++;
            case (ready_mode)
                0:       inst_ready = 1'b1;
                1:       inst_ready = 1'($urandom_range(1, 0));
                default: inst_ready = 1'b0;
            endcase
            if (inst_valid && inst_ready) begin
                got_q.push_back({inst_last, inst_data});
                pop_cnt++;
            end
            hold_prev = inst_valid && !inst_ready;
            held      = {inst_last, inst_data};
            if (req_cnt - pop_cnt > DEPTH) ovf_err++;
        end
    end

    task automatic clear_model();
        req_cnt = 0; pop_cnt = 0; bd_cnt = 0; done_cnt = 0;
        ovf_err = 0; stab_err = 0; cur_block = -1;
        got_q.delete(); tog_addr_q.delete(); tog_size_q.delete();
    endtask

    task automatic build_exp(input int nb, input int size);
        exp_q.delete();
        for (int b = 0; b < nb; b++)
            for (int w = 0; w < size; w++)
                exp_q.push_back({1'(w == size - 1), mem_word(salt, b, w)});
    endtask

    task automatic start_prog(input logic [XW-1:0] base, input int size, input int nb);
        @(negedge clk);
        inst_base_addr  = base;
        inst_block_size = 11'(size);
        num_blocks      = 16'(nb);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (done_cnt == 0) begin
            n_fail++;
            $display("FAIL %s_timeout: no done pulse within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({decoder_ld_req_in, imem_rd_req, imem_rd_block_done, inst_valid, inst_last, busy, done} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 0000000",
                     {decoder_ld_req_in, imem_rd_req, imem_rd_block_done, inst_valid, inst_last, busy, done});
        end
        n_checks++;
        if (decoder_ld_addr !== '0 || decoder_ld_req_size !== '0) begin
            n_fail++;
            $display("FAIL reset_load_port: addr %h size %h required 0/0", decoder_ld_addr, decoder_ld_req_size);
        end
        reset = 1'b0;
        @(negedge clk);
        clear_model();
    endtask

    task automatic test_single_block();
        salt = 8'h11; ready_mode = 0; lat_min = 1; lat_max = 1; ready_delay = 3;
        clear_model();
        build_exp(1, 4);
        start_prog(42'h1000, 4, 1);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b required 1", busy); end
        wait_done(200, "single");
        n_checks++;
        if (tog_addr_q.size() !== 1) begin
            n_fail++; $display("FAIL single_toggles: got %0d required 1", tog_addr_q.size());
        end else begin
            n_checks++;
            if (tog_addr_q[0] !== 42'h1000 || tog_size_q[0] !== 16'd16) begin
                n_fail++; $display("FAIL single_load: addr %h size %0d required 1000/16", tog_addr_q[0], tog_size_q[0]);
            end
        end
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL single_count: got %0d words required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL single_word[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (bd_cnt !== 1 || done_cnt !== 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL single_pulses: block_done %0d done %0d busy %b required 1/1/0", bd_cnt, done_cnt, busy);
        end
    endtask

    task automatic test_multi_block();
        logic [XW-1:0] exp_addr;
        salt = 8'h22; ready_mode = 0; lat_min = 1; lat_max = 2; ready_delay = 2;
        clear_model();
        build_exp(3, 8);
        start_prog(42'h1000, 8, 3);
        wait_done(600, "multi");
        n_checks++;
        if (tog_addr_q.size() !== 3) begin
            n_fail++; $display("FAIL multi_toggles: got %0d required 3", tog_addr_q.size());
        end
        for (int b = 0; b < 3 && b < tog_addr_q.size(); b++) begin
            exp_addr = 42'h1000 + 42'(b * 32);
            n_checks++;
            if (tog_addr_q[b] !== exp_addr || tog_size_q[b] !== 16'd32) begin
                n_fail++; $display("FAIL multi_load[%0d]: addr %h size %0d required %h/32", b, tog_addr_q[b], tog_size_q[b], exp_addr);
            end
        end
        n_checks++;
        if (got_q.size() !== 24) begin
            n_fail++; $display("FAIL multi_count: got %0d words required 24", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL multi_word[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (bd_cnt !== 3 || done_cnt !== 1) begin
            n_fail++; $display("FAIL multi_pulses: block_done %0d done %0d required 3/1", bd_cnt, done_cnt);
        end
    endtask

    task automatic test_backpressure();
        salt = 8'h33; ready_mode = 2; lat_min = 1; lat_max = 3; ready_delay = 1;
        clear_model();
        build_exp(1, 8);
        start_prog(42'h3000, 8, 1);
        repeat (30) @(negedge clk);
        n_checks++;
        if (req_cnt !== DEPTH || got_q.size() !== 0) begin
            n_fail++; $display("FAIL bp_stall: rd_req count %0d words %0d required %0d/0", req_cnt, got_q.size(), DEPTH);
        end
        n_checks++;
        if (inst_valid !== 1'b1 || inst_data !== mem_word(salt, 0, 0)) begin
            n_fail++; $display("FAIL bp_head: valid %b data %h required 1/%h", inst_valid, inst_data, mem_word(salt, 0, 0));
        end
        ready_mode = 0;
        wait_done(200, "bp");
        n_checks++;
        if (got_q.size() !== 8 || req_cnt !== 8) begin
            n_fail++; $display("FAIL bp_count: words %0d reads %0d required 8/8", got_q.size(), req_cnt);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL bp_word[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (stab_err !== 0 || ovf_err !== 0) begin
            n_fail++; $display("FAIL bp_integrity: stability errors %0d credit errors %0d required 0/0", stab_err, ovf_err);
        end
    endtask

    task automatic test_zero_cases();
        ready_mode = 0;
        for (int c = 0; c < 2; c++) begin
            clear_model();
            if (c == 0) start_prog(42'h1000, 0, 2);
            else        start_prog(42'h1000, 4, 0);
            n_checks++;
            if (done !== 1'b1) begin
                n_fail++; $display("FAIL zero%0d_done: got %b required 1 one cycle after start", c, done);
            end
            repeat (5) @(negedge clk);
            n_checks++;
            if (tog_addr_q.size() !== 0 || req_cnt !== 0 || done_cnt !== 1 || busy !== 1'b0) begin
                n_fail++; $display("FAIL zero%0d_quiet: toggles %0d reads %0d done %0d busy %b required 0/0/1/0",
                                   c, tog_addr_q.size(), req_cnt, done_cnt, busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        salt = 8'h44; ready_mode = 1; lat_min = 2; lat_max = 4; ready_delay = 2;
        clear_model();
        start_prog(42'h1000, 8, 2);
        while (req_cnt < 3 && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (req_cnt < 3) begin n_fail++; $display("FAIL midrst_reach: only %0d reads issued", req_cnt); end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({decoder_ld_req_in, imem_rd_req, imem_rd_block_done, inst_valid, inst_last, busy, done} !== 7'b0
            || decoder_ld_addr !== '0 || decoder_ld_req_size !== '0 || inst_data !== '0) begin
            n_fail++; $display("FAIL midrst_outputs: flags %b addr %h size %h data %h required all 0",
                               {decoder_ld_req_in, imem_rd_req, imem_rd_block_done, inst_valid, inst_last, busy, done},
                               decoder_ld_addr, decoder_ld_req_size, inst_data);
        end
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (done_cnt !== 0 || bd_cnt !== 0) begin
            n_fail++; $display("FAIL midrst_pulses: done %0d block_done %0d required 0/0", done_cnt, bd_cnt);
        end
        @(negedge clk);
        salt = 8'h55; ready_mode = 0; lat_min = 1; lat_max = 2;
        clear_model();
        build_exp(2, 4);
        start_prog(42'h2000, 4, 2);
        wait_done(300, "midrst");
        n_checks++;
        if (tog_addr_q.size() !== 2) begin
            n_fail++; $display("FAIL midrst_toggles: got %0d required 2", tog_addr_q.size());
        end else begin
            n_checks++;
            if (tog_addr_q[0] !== 42'h2000 || tog_addr_q[1] !== 42'h2010) begin
                n_fail++; $display("FAIL midrst_addr: got %h,%h required 2000,2010", tog_addr_q[0], tog_addr_q[1]);
            end
        end
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL midrst_count: got %0d words required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL midrst_word[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random_latency();
        salt = 8'h66; ready_mode = 1; lat_min = 1; lat_max = 5;
        ready_delay = int'($urandom_range(6, 1));
        clear_model();
        build_exp(3, 6);
        start_prog(42'h4000, 6, 3);
        wait_done(2000, "rand");
        n_checks++;
        if (got_q.size() !== 18) begin
            n_fail++; $display("FAIL rand_count: got %0d words required 18", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rand_word[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (ovf_err !== 0 || stab_err !== 0) begin
            n_fail++; $display("FAIL rand_integrity: credit errors %0d stability errors %0d required 0/0", ovf_err, stab_err);
        end
        n_checks++;
        if (bd_cnt !== 3 || done_cnt !== 1) begin
            n_fail++; $display("FAIL rand_pulses: block_done %0d done %0d required 3/1", bd_cnt, done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_multi_block();
        test_backpressure();
        test_zero_cases();
        test_reset_mid();
        test_random_latency();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
